// File: rtl/friscv_arb_pkg.sv
// rtl/friscv_arb_pkg.sv - shared types for the fetch/data memory arbiter
package friscv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } arb_state_t;

  // Requester ids double as bit positions in the req/gnt vectors
  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } req_id_t;

endpackage

// File: rtl/friscv_rr_arbiter.sv
// rtl/friscv_rr_arbiter.sv - 2-way arbiter, round-robin or data-priority (FRISCV_ARB_DATA_PRIO_EN)
module friscv_rr_arbiter
  import friscv_arb_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output req_id_t    last_grant
);

  always_comb begin
    gnt = 2'b00;
`ifdef FRISCV_ARB_DATA_PRIO_EN
    if (req[1])
      gnt = 2'b10;
    else if (req[0])
      gnt = 2'b01;
`else
    // On contention serve whoever did not win last time
    if (req == 2'b11)
      gnt = (last_grant == REQ_DATA) ? 2'b01 : 2'b10;
    else
      gnt = req;
`endif
  end

  // Pointer tracks the latest winner in both builds; it only steers round-robin
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      last_grant <= REQ_DATA;
    else if (srst)
      last_grant <= REQ_DATA;
    else if (advance && (req != 2'b00))
      last_grant <= gnt[1] ? REQ_DATA : REQ_INST;
  end

endmodule

// File: rtl/friscv_mem_arbiter.sv
// rtl/friscv_mem_arbiter.sv - shares one RAM port between fetch and load/store
// Optional data-over-fetch fixed priority with FRISCV_ARB_DATA_PRIO_EN.
module friscv_mem_arbiter
  import friscv_arb_pkg::*;
#(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic              inst_en,
  input  logic [ADDRW-1:0]  inst_addr,
  output logic [XLEN-1:0]   inst_rdata,
  output logic              inst_ready,
  input  logic              data_en,
  input  logic              data_wr,
  input  logic [ADDRW-1:0]  data_addr,
  input  logic [XLEN-1:0]   data_wdata,
  input  logic [XLEN/8-1:0] data_strb,
  output logic [XLEN-1:0]   data_rdata,
  output logic              data_ready,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDRW-1:0]  ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic [XLEN/8-1:0] ram_strb,
  input  logic [XLEN-1:0]   ram_rdata,
  input  logic              ram_ready
);

  arb_state_t state, state_nxt;
  logic [1:0] gnt;
  logic       advance;
  req_id_t    last_grant;

  assign advance = (state == IDLE);

  friscv_rr_arbiter u_arb (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .srst       (srst),
    .req        ({data_en, inst_en}),
    .advance    (advance),
    .gnt        (gnt),
    .last_grant (last_grant)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      state <= IDLE;
    else if (srst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Completion and read data are forwarded combinationally to the owner only
  always_comb begin
    state_nxt  = state;
    ram_en     = 1'b0;
    inst_ready = 1'b0;
    data_ready = 1'b0;
    inst_rdata = '0;
    data_rdata = '0;
    case (state)
      IDLE: begin
        if (gnt[0])
          state_nxt = GNT_INST;
        else if (gnt[1])
          state_nxt = GNT_DATA;
      end
      GNT_INST: begin
        ram_en = 1'b1;
        if (ram_ready) begin
          inst_ready = 1'b1;
          inst_rdata = ram_rdata;
          state_nxt  = IDLE;
        end
      end
      GNT_DATA: begin
        ram_en = 1'b1;
        if (ram_ready) begin
          data_ready = 1'b1;
          data_rdata = ram_rdata;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload is captured once at grant time and held for the whole transaction
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_strb  <= '0;
    end else if (srst) begin
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_strb  <= '0;
    end else if (state == IDLE) begin
      if (gnt[0]) begin
        ram_wr    <= 1'b0;
        ram_addr  <= inst_addr;
        ram_wdata <= '0;
        ram_strb  <= '0;
      end else if (gnt[1]) begin
        ram_wr    <= data_wr;
        ram_addr  <= data_addr;
        ram_wdata <= data_wdata;
        ram_strb  <= data_strb;
      end
    end
  end

  a_inst_hold: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    (state == GNT_INST) |-> inst_en);
  a_data_hold: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    (state == GNT_DATA) |-> data_en);
  a_idle_quiet: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    (state == IDLE) |-> !(inst_ready || data_ready));
  a_ptr_inst: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    (state == GNT_INST) |-> (last_grant == REQ_INST));
  a_ptr_data: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    (state == GNT_DATA) |-> (last_grant == REQ_DATA));

endmodule

// File: tb/tb_friscv_mem_arbiter.sv
// tb/tb_friscv_mem_arbiter.sv - directed table-driven bench for friscv_mem_arbiter
module tb_friscv_mem_arbiter;

`ifdef FRISCV_ARB_DATA_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn, srst;
  logic        inst_en, data_en, data_wr, ram_ready;
  logic [15:0] inst_addr, data_addr;
  logic [31:0] data_wdata, ram_rdata;
  logic [3:0]  data_strb;
  logic [31:0] inst_rdata, data_rdata, ram_wdata;
  logic        inst_ready, data_ready, ram_en, ram_wr;
  logic [15:0] ram_addr;
  logic [3:0]  ram_strb;

  int total = 0;
  int passed = 0;

  always #5 aclk = ~aclk;

  friscv_mem_arbiter #(.ADDRW(16), .XLEN(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_strb(data_strb), .data_rdata(data_rdata), .data_ready(data_ready),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_strb(ram_strb), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  typedef struct {
    logic        s, ie;
    logic [15:0] ia;
    logic        de, dw;
    logic [15:0] da;
    logic [31:0] wd;
    logic [3:0]  st;
    logic        rr;
    logic [31:0] rd;
    logic        e_en;
    logic [15:0] e_addr;
    logic        e_wr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic        e_ir;
    logic [31:0] e_ird;
    logic        e_dr;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic s, ie, input logic [15:0] ia, input logic de, dw, input logic [15:0] da,
    input logic [31:0] wd, input logic [3:0] st, input logic rr, input logic [31:0] rd,
    input logic een, input logic [15:0] ea, input logic ew, input logic [31:0] ewd,
    input logic [3:0] es, input logic eir, input logic [31:0] eird,
    input logic edr, input logic [31:0] edrd);
    vec_t v;
    v.s = s; v.ie = ie; v.ia = ia; v.de = de; v.dw = dw; v.da = da; v.wd = wd; v.st = st;
    v.rr = rr; v.rd = rd; v.e_en = een; v.e_addr = ea; v.e_wr = ew; v.e_wdata = ewd;
    v.e_strb = es; v.e_ir = eir; v.e_ird = eird; v.e_dr = edr; v.e_drd = edrd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ram_en"}, {31'd0, ram_en}, 32'd0);
    chk({tag, " inst_ready"}, {31'd0, inst_ready}, 32'd0);
    chk({tag, " data_ready"}, {31'd0, data_ready}, 32'd0);
    chk({tag, " inst_rdata"}, inst_rdata, 32'd0);
    chk({tag, " data_rdata"}, data_rdata, 32'd0);
  endtask

  initial begin
    aresetn = 1'b0; srst = 1'b0;
    inst_en = 1'b1; inst_addr = 16'h0010;
    data_en = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_strb = '0;
    ram_ready = 1'b0; ram_rdata = '0;

    // Reset held with a pending fetch: everything stays 0
    tick(); tick();
    #2;
    chk_quiet("rst");
    chk("rst ram_addr", {16'd0, ram_addr}, 32'd0);
    chk("rst ram_wr", {31'd0, ram_wr}, 32'd0);
    #1 aresetn = 1'b1;
    tick(); #2;
    chk("rel ram_en", {31'd0, ram_en}, 32'd1);
    chk("rel ram_addr", {16'd0, ram_addr}, 32'h0010);
    ram_ready = 1'b1; ram_rdata = 32'h0050_0093;
    #1;
    chk("rel inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("rel inst_rdata", inst_rdata, 32'h0050_0093);
    chk("rel data_ready", {31'd0, data_ready}, 32'd0);
    tick();
    inst_en = 1'b0; ram_ready = 1'b0;
    #2;
    chk_quiet("rel idle");
    tick();

    // Single fetch
    add(0,1,16'h0010,0,0,16'h0,0,4'h0,1,32'h0050_0093, 0,0,0,0,0, 0,0,0,0);
    add(0,1,16'h0010,0,0,16'h0,0,4'h0,1,32'h0050_0093, 1,16'h0010,0,0,0, 1,32'h0050_0093,0,0);
    add(0,0,16'h0010,0,0,16'h0,0,4'h0,1,32'h0050_0093, 0,0,0,0,0, 0,0,0,0);
    // srst restores last_grant=DATA so the contest starts with fetch
    add(1,0,16'h0,0,0,16'h0,0,4'h0,1,32'h1122_3344, 0,0,0,0,0, 0,0,0,0);
    // Contested requests held six cycles
    for (int k = 0; k < 3; k++) begin
      add(0,1,16'h0020,1,0,16'h0200,0,4'hF,1,32'h1122_3344, 0,0,0,0,0, 0,0,0,0);
      if (PRIO || k == 1)
        add(0,1,16'h0020,1,0,16'h0200,0,4'hF,1,32'h1122_3344, 1,16'h0200,0,0,4'hF, 0,0,1,32'h1122_3344);
      else
        add(0,1,16'h0020,1,0,16'h0200,0,4'hF,1,32'h1122_3344, 1,16'h0020,0,0,4'h0, 1,32'h1122_3344,0,0);
    end
    add(0,0,16'h0020,0,0,16'h0200,0,4'hF,1,32'h1122_3344, 0,0,0,0,0, 0,0,0,0);
    // Slow write with a fetch arriving mid-transaction
    add(0,0,16'h0040,1,1,16'h0100,32'hDEAD_BEEF,4'h3,0,32'hCAFE_F00D, 0,0,0,0,0, 0,0,0,0);
    for (int k = 0; k < 3; k++)
      add(0,1,16'h0040,1,1,16'h0100,32'hDEAD_BEEF,4'h3,0,32'hCAFE_F00D, 1,16'h0100,1,32'hDEAD_BEEF,4'h3, 0,0,0,0);
    add(0,1,16'h0040,1,1,16'h0100,32'hDEAD_BEEF,4'h3,1,32'hCAFE_F00D, 1,16'h0100,1,32'hDEAD_BEEF,4'h3, 0,0,1,32'hCAFE_F00D);
    add(0,1,16'h0040,0,0,16'h0100,32'hDEAD_BEEF,4'h3,1,32'hCAFE_F00D, 0,0,0,0,0, 0,0,0,0);
    add(0,1,16'h0040,0,0,16'h0100,32'hDEAD_BEEF,4'h3,1,32'hCAFE_F00D, 1,16'h0040,0,0,4'h0, 1,32'hCAFE_F00D,0,0);
    add(0,0,16'h0040,0,0,16'h0100,32'h0,4'h0,1,32'hCAFE_F00D, 0,0,0,0,0, 0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      srst = vecs[i].s; inst_en = vecs[i].ie; inst_addr = vecs[i].ia;
      data_en = vecs[i].de; data_wr = vecs[i].dw; data_addr = vecs[i].da;
      data_wdata = vecs[i].wd; data_strb = vecs[i].st;
      ram_ready = vecs[i].rr; ram_rdata = vecs[i].rd;
      #2;
      chk($sformatf("v%0d ram_en", i), {31'd0, ram_en}, {31'd0, vecs[i].e_en});
      if (vecs[i].e_en) begin
        chk($sformatf("v%0d ram_addr", i), {16'd0, ram_addr}, {16'd0, vecs[i].e_addr});
        chk($sformatf("v%0d ram_wr", i), {31'd0, ram_wr}, {31'd0, vecs[i].e_wr});
        chk($sformatf("v%0d ram_wdata", i), ram_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d ram_strb", i), {28'd0, ram_strb}, {28'd0, vecs[i].e_strb});
      end
      chk($sformatf("v%0d inst_ready", i), {31'd0, inst_ready}, {31'd0, vecs[i].e_ir});
      chk($sformatf("v%0d inst_rdata", i), inst_rdata, vecs[i].e_ird);
      chk($sformatf("v%0d data_ready", i), {31'd0, data_ready}, {31'd0, vecs[i].e_dr});
      chk($sformatf("v%0d data_rdata", i), data_rdata, vecs[i].e_drd);
      tick();
    end
    srst = 1'b0;

    // Async reset in the middle of a stalled data read
    data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h0300; ram_ready = 1'b0;
    #2;
    chk("mid idle ram_en", {31'd0, ram_en}, 32'd0);
    tick(); #2;
    chk("mid gnt ram_en", {31'd0, ram_en}, 32'd1);
    chk("mid gnt ram_addr", {16'd0, ram_addr}, 32'h0300);
    aresetn = 1'b0; ram_ready = 1'b1; ram_rdata = 32'h1234_5678;
    #1;
    chk_quiet("mid rst");
    chk("mid rst ram_addr", {16'd0, ram_addr}, 32'd0);
    tick();
    data_en = 1'b0; aresetn = 1'b1;
    #2;
    chk_quiet("mid rel");
    tick(); #2;
    chk_quiet("mid after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
